// File: rtl/sisc_pkg.sv
// Shared constants and loader state encoding for the SISC boot-time program loader.
// The CHECKSUM_EN macro adds the CSUM state that consumes the trailing checksum byte.
package sisc_pkg;

  localparam int          WIDTH    = 32;
  localparam int          ADDRSIZE = 12;
  localparam logic [31:0] MEMSIZE  = 32'd1 << ADDRSIZE;
  localparam int          HDR_W    = 16;
  localparam int          LANES    = WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
`ifdef CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } loader_state_t;

  // Every state that consumes bytes from the stream counts as busy.
  function automatic logic state_busy(input loader_state_t s);
    case (s)
      ST_HDR_HI, ST_HDR_LO, ST_DATA: return 1'b1;
`ifdef CHECKSUM_EN
      ST_CSUM:                       return 1'b1;
`endif
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and memory write bus of the program loader.
// master = loader side, slave = stream source / memory side.
interface program_loader_if;
  import sisc_pkg::*;

  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                rx_ready;
  logic                mem_we;
  logic [ADDRSIZE-1:0] mem_addr;
  logic [WIDTH-1:0]    mem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs accepted data bytes MSB-first into WIDTH-bit words and pulses word_valid_o
// for exactly one cycle after the last lane of each word; word_o holds until the next word.
module word_assembler
  import sisc_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_i,
  output logic             lane_last_o,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o
);

  localparam int            LW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LANE_MAX = LW'(LANES - 1);

  logic [LW-1:0]    lane_q, lane_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             word_valid_q, word_valid_d;

  assign lane_last_o  = (lane_q == LANE_MAX);
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

  always_comb begin
    lane_d       = lane_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear_i) begin
      lane_d  = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      shift_d = (shift_q << 8) | WIDTH'(byte_i);
      if (lane_last_o) begin
        lane_d       = '0;
        word_d       = shift_d;
        word_valid_d = 1'b1;
      end else begin
        lane_d = lane_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q       <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a counted byte image, writes it as words from address 0 and
// holds the CPU in reset until the image is complete. Optional macro: CHECKSUM_EN.
module program_loader
  import sisc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  program_loader_if.master  bus,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WL = ADDRSIZE + 1;

`ifdef CHECKSUM_EN
  localparam loader_state_t ST_AFTER_DATA = ST_CSUM;
`else
  localparam loader_state_t ST_AFTER_DATA = ST_DONE;
`endif

  loader_state_t       state_q, state_d;
  logic [7:0]          hdr_hi_q, hdr_hi_d;
  logic [WL-1:0]       words_left_q, words_left_d;
  logic [ADDRSIZE-1:0] waddr_q, waddr_d;
  logic [ADDRSIZE-1:0] mem_addr_q, mem_addr_d;
  logic [HDR_W-1:0]    n_hdr;
  logic                byte_acc, data_acc, start_acc, lane_last;
`ifdef CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  assign busy         = state_busy(state_q);
  assign done         = (state_q == ST_DONE);
  assign err          = (state_q == ST_ERR);
  assign cpu_reset    = ~done;
  assign bus.rx_ready = busy;
  assign bus.mem_addr = mem_addr_q;

  assign byte_acc  = bus.rx_valid && bus.rx_ready;
  assign data_acc  = byte_acc && (state_q == ST_DATA);
  assign start_acc = start && !busy;
  assign n_hdr     = {hdr_hi_q, bus.rx_data};

  word_assembler u_word_assembler (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (start_acc),
    .byte_valid_i (data_acc),
    .byte_i       (bus.rx_data),
    .lane_last_o  (lane_last),
    .word_o       (bus.mem_wdata),
    .word_valid_o (bus.mem_we)
  );

  always_comb begin
    state_d      = state_q;
    hdr_hi_d     = hdr_hi_q;
    words_left_d = words_left_q;
    waddr_d      = waddr_q;
    mem_addr_d   = mem_addr_q;
`ifdef CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      ST_HDR_HI: begin
        if (byte_acc) begin
          hdr_hi_d = bus.rx_data;
          state_d  = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (byte_acc) begin
          waddr_d      = '0;
          words_left_d = WL'(n_hdr);
          if (n_hdr == '0)                state_d = ST_AFTER_DATA;
          else if (32'(n_hdr) > MEMSIZE)  state_d = ST_ERR;
          else                            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (data_acc) begin
`ifdef CHECKSUM_EN
          csum_d = csum_q ^ bus.rx_data;
`endif
          // Latch the write address now so it lines up with the assembler's write pulse.
          if (lane_last) begin
            mem_addr_d   = waddr_q;
            waddr_d      = waddr_q + ADDRSIZE'(1);
            words_left_d = words_left_q - WL'(1);
            if (words_left_q == WL'(1)) state_d = ST_AFTER_DATA;
          end
        end
      end
`ifdef CHECKSUM_EN
      ST_CSUM: begin
        if (byte_acc) state_d = (bus.rx_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: begin
        if (start_acc) begin
          state_d = ST_HDR_HI;
`ifdef CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      hdr_hi_q     <= '0;
      words_left_q <= '0;
      waddr_q      <= '0;
      mem_addr_q   <= '0;
`ifdef CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hdr_hi_q     <= hdr_hi_d;
      words_left_q <= words_left_d;
      waddr_q      <= waddr_d;
      mem_addr_q   <= mem_addr_d;
`ifdef CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed loads with random data and gaps,
// compared against a byte-level image model (word list built by arithmetic packing).
module tb_program_loader;
  import sisc_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic cpu_reset, busy, done, err;

  program_loader_if bus ();

  program_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDRSIZE-1:0] a;
    logic [WIDTH-1:0]    d;
  } wr_t;

  int checks = 0;
  int errors = 0;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] csum_m;
  longint unsigned acc_m;
  int         nbytes_m;
  logic [7:0] fixed_img[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_t w;
      w.a = bus.mem_addr;
      w.d = bus.mem_wdata;
      got_q.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Image model: stream bytes, running XOR and the expected word list.
  task automatic build_begin(input int n);
    tx_q.delete();
    exp_q.delete();
    csum_m   = 8'h00;
    acc_m    = 0;
    nbytes_m = 0;
    tx_q.push_back(8'(n / 256));
    tx_q.push_back(8'(n % 256));
  endtask

  task automatic add_byte(input logic [7:0] b);
    wr_t w;
    tx_q.push_back(b);
    csum_m = csum_m ^ b;
    acc_m  = acc_m * 256 + longint'(b);
    nbytes_m++;
    if (nbytes_m % LANES == 0) begin
      w.a = ADDRSIZE'((nbytes_m / LANES - 1) % int'(MEMSIZE));
      w.d = WIDTH'(acc_m);
      exp_q.push_back(w);
      acc_m = 0;
    end
  endtask

  task automatic add_random_words(input int n);
    for (int i = 0; i < n * LANES; i++) add_byte(8'($urandom_range(255)));
  endtask

  task automatic build_end(input logic [7:0] corrupt);
`ifdef CHECKSUM_EN
    tx_q.push_back(csum_m ^ corrupt);
`else
    if (corrupt != 8'h00) tx_q.push_back(8'h00);
`endif
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":rx_ready_after_start"}, 64'(bus.rx_ready), 64'(1));
  endtask

  // Called just after a negedge; returns just after the negedge that follows the last accepted byte.
  task automatic send_all(input string tag, input int gap_pct, input int start_at, input int max_bytes);
    int idx = 0;
    int budget = 0;
    int limit;
    bit pulsed = 1'b0;
    bit fire = 1'b0;
    bit v;
    limit = (max_bytes < tx_q.size()) ? max_bytes : tx_q.size();
    while (idx < limit && budget < limit * 20 + 100) begin
      v = ($urandom_range(99) >= 32'(gap_pct));
      bus.rx_valid = v;
      bus.rx_data  = v ? tx_q[idx] : 8'($urandom_range(255));
      if (!pulsed && start_at >= 0 && idx == start_at) begin
        start  = 1'b1;
        pulsed = 1'b1;
        fire   = 1'b1;
      end
      if (v && bus.rx_ready === 1'b1) idx++;
      @(negedge clk);
      budget++;
      if (fire) begin
        start = 1'b0;
        fire  = 1'b0;
        chk({tag, ":start_ignored_busy"}, 64'(busy), 64'(1));
      end
    end
    bus.rx_valid = 1'b0;
    chk({tag, ":bytes_sent"}, 64'(idx), 64'(limit));
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, ":write_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ":waddr"}, 64'(got_q[i].a), 64'(exp_q[i].a));
      chk({tag, ":wdata"}, 64'(got_q[i].d), 64'(exp_q[i].d));
    end
    if (exp_q.size() > 0) begin
      chk({tag, ":addr_hold"}, 64'(bus.mem_addr), 64'(exp_q[exp_q.size()-1].a));
      chk({tag, ":wdata_hold"}, 64'(bus.mem_wdata), 64'(exp_q[exp_q.size()-1].d));
    end
  endtask

  task automatic run_load(input string tag, input int gap_pct, input int start_at, input bit exp_ok);
    got_q.delete();
    do_start(tag);
    send_all(tag, gap_pct, start_at, tx_q.size());
    chk({tag, ":done"}, 64'(done), 64'(exp_ok));
    chk({tag, ":err"}, 64'(err), 64'(!exp_ok));
    chk({tag, ":cpu_reset"}, 64'(cpu_reset), 64'(!exp_ok));
    chk({tag, ":rx_ready_end"}, 64'(bus.rx_ready), 64'(0));
    chk({tag, ":busy_end"}, 64'(busy), 64'(0));
`ifndef CHECKSUM_EN
    if (exp_q.size() > 0) chk({tag, ":last_we_with_done"}, 64'(bus.mem_we), 64'(1));
`endif
    repeat (3) @(negedge clk);
    check_writes(tag);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ":cpu_reset"}, 64'(cpu_reset), 64'(1));
    chk({tag, ":rx_ready"}, 64'(bus.rx_ready), 64'(0));
    chk({tag, ":mem_we"}, 64'(bus.mem_we), 64'(0));
    chk({tag, ":mem_addr"}, 64'(bus.mem_addr), 64'(0));
    chk({tag, ":mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    chk({tag, ":busy"}, 64'(busy), 64'(0));
    chk({tag, ":done"}, 64'(done), 64'(0));
    chk({tag, ":err"}, 64'(err), 64'(0));
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("idle");

    build_begin(2);
    foreach (fixed_img[i]) add_byte(fixed_img[i]);
    build_end(8'h00);
    run_load("fixed_good", 0, -1, 1'b1);
    $display("load fixed_good: writes=%0d done=%0b", got_q.size(), done);

`ifdef CHECKSUM_EN
    build_begin(2);
    foreach (fixed_img[i]) add_byte(fixed_img[i]);
    build_end(8'h01);
    run_load("fixed_badsum", 0, -1, 1'b0);
    $display("load fixed_badsum: writes=%0d err=%0b", got_q.size(), err);
`endif

    build_begin(16'h1001);
    run_load("hdr_too_big", 0, -1, 1'b0);
    $display("load hdr_too_big: writes=%0d err=%0b", got_q.size(), err);

    build_begin(0);
    build_end(8'h00);
    run_load("empty", 0, -1, 1'b1);
    $display("load empty: writes=%0d done=%0b", got_q.size(), done);

    build_begin(3);
    add_random_words(3);
    build_end(8'h00);
    run_load("rand3_nogap", 0, -1, 1'b1);
    $display("load rand3_nogap: writes=%0d done=%0b", got_q.size(), done);
    run_load("rand3_gaps", 40, 6, 1'b1);
    $display("load rand3_gaps: writes=%0d done=%0b", got_q.size(), done);

    build_begin(2);
    add_random_words(2);
    build_end(8'h00);
    got_q.delete();
    do_start("abort");
    send_all("abort", 0, -1, 7);
    reset_n = 1'b0;
    #1;
    chk_reset_state("abort_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort:partial_writes", 64'(got_q.size()), 64'(1));
    if (got_q.size() > 0) chk("abort:partial_addr", 64'(got_q[0].a), 64'(0));
    $display("load abort: writes=%0d", got_q.size());
    build_begin(2);
    add_random_words(2);
    build_end(8'h00);
    run_load("after_abort", 0, -1, 1'b1);
    $display("load after_abort: writes=%0d done=%0b", got_q.size(), done);

    build_begin(int'(MEMSIZE));
    add_random_words(int'(MEMSIZE));
    build_end(8'h00);
    run_load("full_mem", 0, -1, 1'b1);
    $display("load full_mem: writes=%0d done=%0b", got_q.size(), done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
